// File: rtl/parity_frame_accumulator.sv
// Streaming per-frame parity generator/checker with a registered result slot,
// valid/ready handshakes on both sides and a saturating parity-error counter.
module parity_frame_accumulator #(
    parameter int width      = 8,
    parameter int odd        = 1,
    parameter int max_beats  = 15,
    parameter int beat_width = 4,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst_x,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [width-1:0]      i_data,
    input  logic                  i_last,
    input  logic                  i_check,
    input  logic                  i_parity,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_parity,
    output logic [beat_width-1:0] o_beats,
    output logic                  o_error,
    output logic                  o_overrun,
    input  logic                  i_clear,
    output logic [cnt_width-1:0]  o_err_count
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam logic [beat_width-1:0] last_beat = beat_width'(max_beats);
    localparam logic                  odd_bit   = (odd != 0);

    state_t                state;
    logic                  acc;
    logic [beat_width-1:0] beat;

    logic                  accept;
    logic                  acc_n;
    logic [beat_width-1:0] beat_n;
    logic                  frame_end;
    logic                  parity_n;
    logic                  err_n;
    logic                  load;

    // A pending result only blocks input while the consumer is stalling it.
    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    always_comb begin
        acc_n     = acc ^ (^i_data);
        beat_n    = (state == IDLE) ? beat_width'(1) : beat + beat_width'(1);
        frame_end = i_last || (beat_n == last_beat);
        parity_n  = acc_n ^ odd_bit;
        err_n     = i_check && (i_parity != parity_n);
        load      = accept && frame_end;
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state       <= IDLE;
            acc         <= 1'b0;
            beat        <= '0;
            o_valid     <= 1'b0;
            o_parity    <= 1'b0;
            o_beats     <= '0;
            o_error     <= 1'b0;
            o_overrun   <= 1'b0;
            o_err_count <= '0;
        end else begin
            if (accept) begin
                if (frame_end) begin
                    state <= IDLE;
                    acc   <= 1'b0;
                    beat  <= '0;
                end else begin
                    state <= ACCUM;
                    acc   <= acc_n;
                    beat  <= beat_n;
                end
            end

            // A same-cycle load beats a drain, so back-to-back frames keep o_valid high.
            if (load) begin
                o_valid   <= 1'b1;
                o_parity  <= parity_n;
                o_beats   <= beat_n;
                o_error   <= err_n;
                o_overrun <= !i_last;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end

            if (i_clear) begin
                o_err_count <= '0;
            end else if (load && err_n && (o_err_count != '1)) begin
                o_err_count <= o_err_count + cnt_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_accumulator.sv
// Directed bench: an odd-parity instance with a 2-bit error counter and an
// even-parity instance, both driven by the same stimulus.
module tb_parity_frame_accumulator;

    logic       clk;
    logic       rst_x;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_last;
    logic       i_check;
    logic       i_parity;
    logic       i_ready;
    logic       i_clear;

    logic       o_ready, o_valid, o_parity, o_error, o_overrun;
    logic [3:0] o_beats;
    logic [1:0] o_err_count;

    logic       e_ready, e_valid, e_parity, e_error, e_overrun;
    logic [3:0] e_beats;
    logic [7:0] e_err_count;

    int total = 0;
    int bad   = 0;

    parity_frame_accumulator #(
        .width(8), .odd(1), .max_beats(15), .beat_width(4), .cnt_width(2)
    ) dut (
        .clk(clk), .rst_x(rst_x), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_last(i_last), .i_check(i_check), .i_parity(i_parity),
        .o_valid(o_valid), .i_ready(i_ready), .o_parity(o_parity), .o_beats(o_beats),
        .o_error(o_error), .o_overrun(o_overrun), .i_clear(i_clear),
        .o_err_count(o_err_count)
    );

    parity_frame_accumulator #(
        .width(8), .odd(0), .max_beats(15), .beat_width(4), .cnt_width(8)
    ) dut_even (
        .clk(clk), .rst_x(rst_x), .i_valid(i_valid), .o_ready(e_ready),
        .i_data(i_data), .i_last(i_last), .i_check(i_check), .i_parity(i_parity),
        .o_valid(e_valid), .i_ready(i_ready), .o_parity(e_parity), .o_beats(e_beats),
        .o_error(e_error), .o_overrun(e_overrun), .i_clear(i_clear),
        .o_err_count(e_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One accepted beat: inputs are set between edges and dropped 1 ns after the edge.
    task automatic apply_stimulus(input logic [7:0] data, input logic last,
                                  input logic chk, input logic par);
        i_valid  = 1'b1;
        i_data   = data;
        i_last   = last;
        i_check  = chk;
        i_parity = par;
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        i_last   = 1'b0;
        i_check  = 1'b0;
        i_parity = 1'b0;
        i_data   = 8'h00;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_x    = 1'b0;
        i_valid  = 1'b0;
        i_data   = 8'h00;
        i_last   = 1'b0;
        i_check  = 1'b0;
        i_parity = 1'b0;
        i_ready  = 1'b1;
        i_clear  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", o_valid, 0);
        check_output("rst_ready", o_ready, 1);
        check_output("rst_parity", o_parity, 0);
        check_output("rst_beats", o_beats, 0);
        check_output("rst_errcnt", o_err_count, 0);
        rst_x = 1'b1;
        idle_cycle();

        // single zero beat
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
        check_output("t1_valid", o_valid, 1);
        check_output("t1_parity", o_parity, 1);
        check_output("t1_beats", o_beats, 1);
        check_output("t1_error", o_error, 0);
        check_output("t1_overrun", o_overrun, 0);
        check_output("t1_even_parity", e_parity, 0);

        // three-beat frame, back to back with the drain of the previous result
        apply_stimulus(8'h01, 1'b0, 1'b0, 1'b0);
        check_output("t2_drained", o_valid, 0);
        apply_stimulus(8'h03, 1'b0, 1'b0, 1'b0);
        apply_stimulus(8'h07, 1'b1, 1'b0, 1'b0);
        check_output("t2_valid", o_valid, 1);
        check_output("t2_parity", o_parity, 1);
        check_output("t2_beats", o_beats, 3);
        check_output("t2_even_parity", e_parity, 0);
        check_output("t2_even_beats", e_beats, 3);
        idle_cycle();

        // error frames, counter saturates at 3, then clear
        apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0);
        check_output("t3_err1", o_error, 1);
        check_output("t3_cnt1", o_err_count, 1);
        check_output("t3_even_err", e_error, 0);
        apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0);
        check_output("t3_valid_held", o_valid, 1);
        check_output("t3_cnt2", o_err_count, 2);
        apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0);
        check_output("t3_cnt3", o_err_count, 3);
        apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0);
        check_output("t3_err4", o_error, 1);
        check_output("t3_cnt_sat", o_err_count, 3);
        check_output("t3_even_cnt", e_err_count, 0);
        i_clear = 1'b1;
        idle_cycle();
        i_clear = 1'b0;
        check_output("t3_cleared", o_err_count, 0);

        // check ignored on non-final beats, parity matches on final beat
        apply_stimulus(8'h01, 1'b0, 1'b1, 1'b1);
        apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0);
        check_output("t3_match_err", o_error, 0);
        check_output("t3_match_cnt", o_err_count, 0);
        idle_cycle();

        // 15 beats without last force an overrun close
        for (int i = 0; i < 14; i++) apply_stimulus(8'h01, 1'b0, 1'b0, 1'b0);
        check_output("t4_not_yet", o_valid, 0);
        apply_stimulus(8'h01, 1'b0, 1'b0, 1'b0);
        check_output("t4_valid", o_valid, 1);
        check_output("t4_overrun", o_overrun, 1);
        check_output("t4_beats", o_beats, 15);
        check_output("t4_parity", o_parity, 0);
        check_output("t4_even_parity", e_parity, 1);
        check_output("t4_even_overrun", e_overrun, 1);
        apply_stimulus(8'h80, 1'b1, 1'b0, 1'b0);
        check_output("t4_next_beats", o_beats, 1);
        check_output("t4_next_parity", o_parity, 0);
        check_output("t4_next_overrun", o_overrun, 0);
        idle_cycle();

        // last on the 15th beat is a normal close
        for (int i = 0; i < 14; i++) apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
        check_output("t4b_beats", o_beats, 15);
        check_output("t4b_overrun", o_overrun, 0);
        check_output("t4b_parity", o_parity, 1);
        idle_cycle();

        // backpressure stall, then drain and accept in the same cycle
        i_ready = 1'b0;
        apply_stimulus(8'h03, 1'b1, 1'b0, 1'b0);
        check_output("t5_valid", o_valid, 1);
        check_output("t5_parity", o_parity, 1);
        i_valid = 1'b1;
        i_data  = 8'h07;
        for (int i = 0; i < 5; i++) begin
            check_output("t5_stall_ready", o_ready, 0);
            check_output("t5_stall_even_ready", e_ready, 0);
            idle_cycle();
            check_output("t5_stall_valid", o_valid, 1);
            check_output("t5_stall_beats", o_beats, 1);
            check_output("t5_stall_parity", o_parity, 1);
        end
        i_ready = 1'b1;
        #1;
        check_output("t5_release_ready", o_ready, 1);
        idle_cycle();
        i_valid = 1'b0;
        i_data  = 8'h00;
        check_output("t5_drained", o_valid, 0);
        check_output("t5_beats_held", o_beats, 1);
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
        check_output("t5_beats", o_beats, 2);
        check_output("t5_parity2", o_parity, 0);
        check_output("t5_even_valid", e_valid, 1);

        // reset mid-frame with a pending result
        i_clear = 1'b0;
        apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0);
        check_output("t6_pre_cnt", o_err_count, 1);
        apply_stimulus(8'h01, 1'b0, 1'b0, 1'b0);
        apply_stimulus(8'h02, 1'b0, 1'b0, 1'b0);
        rst_x = 1'b0;
        #2;
        check_output("t6_valid", o_valid, 0);
        check_output("t6_ready", o_ready, 1);
        check_output("t6_parity", o_parity, 0);
        check_output("t6_beats", o_beats, 0);
        check_output("t6_error", o_error, 0);
        check_output("t6_overrun", o_overrun, 0);
        check_output("t6_cnt", o_err_count, 0);
        #1;
        rst_x = 1'b1;
        idle_cycle();
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
        check_output("t6_new_parity", o_parity, 1);
        check_output("t6_new_beats", o_beats, 1);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
